// File: rtl/parking_gate_sequencer.sv
// rtl/parking_gate_sequencer.sv - sensor debounce, entry/exit barrier FSMs, commit arbitration and hour counter
module parking_gate_sequencer #(
  parameter int DEBOUNCE   = 4,
  parameter int TIMEOUT    = 16,
  parameter int HOUR_RESET = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic       entry_badge_uni,
  input  logic       exit_badge_uni,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  input  logic       hour_tick,
  input  logic       hour_load,
  input  logic [4:0] hour_in,
  output logic [4:0] current_hour,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_denied,
  output logic       entry_abort,
  output logic       exit_abort
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DENY,
    S_OPEN,
    S_COMMIT,
    S_WAIT_CLEAR
  } state_e;

  // Index 0 is the entry lane, index 1 the exit lane; both share the same machinery.
  logic [1:0]    sensor_raw;
  logic [1:0]    badge_raw;
  logic [1:0]    space_ok;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_d;
  logic [1:0]    rise;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  state_e        state_q [2];
  state_e        state_d [2];
  logic [TW-1:0] tmr_q [2];
  logic [TW-1:0] tmr_d [2];
  logic [1:0]    uni_q;
  logic [1:0]    uni_d;
  logic [1:0]    grant;
  logic [4:0]    hour_q;
  logic [4:0]    hour_d;

  assign sensor_raw  = {exit_sensor, entry_sensor};
  assign badge_raw   = {exit_badge_uni, entry_badge_uni};
  // The exit lane never checks for space; entry picks the pool matching the badge.
  assign space_ok[0] = entry_badge_uni ? uni_is_vacated_space : is_vacated_space;
  assign space_ok[1] = 1'b1;

  // Exit commits win; an entry commit waits while the exit lane is committing.
  assign grant[1] = (state_q[1] == S_COMMIT);
  assign grant[0] = (state_q[0] == S_COMMIT) && (state_q[1] != S_COMMIT);

  // Debounce: accept a new level after DEBOUNCE consecutive differing synchronised samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A rise is acted on in the very cycle the debounced level flips.
  assign rise = deb_d & ~deb_q;

  // Hour counter next value: load (clamped to 23) beats tick (wraps 23 -> 0).
  always_comb begin
    hour_d = hour_q;
    if (hour_load) begin
      hour_d = (hour_in > 5'd23) ? 5'd23 : hour_in;
    end else if (hour_tick) begin
      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
  end

  // Synchroniser, debounce and hour registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
      hour_q    <= 5'(HOUR_RESET);
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      hour_q  <= hour_d;
    end
  end

  // Lane FSM state, open timer and latched badge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= S_IDLE;
      state_q[1] <= S_IDLE;
      tmr_q[0]   <= '0;
      tmr_q[1]   <= '0;
      uni_q      <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      uni_q   <= uni_d;
    end
  end

  // Lane FSM next state; the timer holds the number of the current open cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      uni_d[i]   = uni_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (rise[i]) state_d[i] = S_CHECK;
        end
        S_CHECK: begin
          uni_d[i]   = badge_raw[i];
          tmr_d[i]   = TW'(1);
          state_d[i] = space_ok[i] ? S_OPEN : S_DENY;
        end
        S_DENY: begin
          state_d[i] = S_WAIT_CLEAR;
        end
        S_OPEN: begin
          tmr_d[i] = tmr_q[i] + 1'b1;
          if (tmr_q[i] == TW'(TIMEOUT)) begin
            state_d[i] = S_WAIT_CLEAR;
          end else if (!deb_q[i]) begin
            state_d[i] = S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (grant[i]) state_d[i] = S_IDLE;
        end
        S_WAIT_CLEAR: begin
          if (!deb_q[i]) state_d[i] = S_IDLE;
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only, so reset clears them at once.
  always_comb begin
    entry_gate_open    = (state_q[0] == S_OPEN);
    exit_gate_open     = (state_q[1] == S_OPEN);
    entry_abort        = (state_q[0] == S_OPEN) && (tmr_q[0] == TW'(TIMEOUT));
    exit_abort         = (state_q[1] == S_OPEN) && (tmr_q[1] == TW'(TIMEOUT));
    entry_denied       = (state_q[0] == S_DENY);
    car_entered        = grant[0];
    is_uni_car_entered = grant[0] & uni_q[0];
    car_exited         = grant[1];
    is_uni_car_exited  = grant[1] & uni_q[1];
  end

  assign current_hour = hour_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb/tb_parking_gate_sequencer.sv - directed and randomized checks of parking_gate_sequencer against a behavioural model
module tb_parking_gate_sequencer;

  localparam int TIMEOUT    = 16;
  localparam int HOUR_RESET = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic       entry_badge_uni = 1'b0;
  logic       exit_badge_uni = 1'b0;
  logic       uni_is_vacated_space = 1'b0;
  logic       is_vacated_space = 1'b0;
  logic       hour_tick = 1'b0;
  logic       hour_load = 1'b0;
  logic [4:0] hour_in = 5'd0;
  logic [4:0] current_hour;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic       entry_gate_open, exit_gate_open, entry_denied, entry_abort, exit_abort;

  int n_checks = 0;
  int n_pass   = 0;

  parking_gate_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .entry_sensor         (entry_sensor),
    .exit_sensor          (exit_sensor),
    .entry_badge_uni      (entry_badge_uni),
    .exit_badge_uni       (exit_badge_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .hour_tick            (hour_tick),
    .hour_load            (hour_load),
    .hour_in              (hour_in),
    .current_hour         (current_hour),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_denied         (entry_denied),
    .entry_abort          (entry_abort),
    .exit_abort           (exit_abort)
  );

  always #5 clk = ~clk;

  // Reference model: each lane is a car-visit phase; the debounced level is
  // whatever the raw sensor showed on four consecutive samples taken 2..5 edges ago.
  localparam int M_IDLE = 0, M_CHECK = 1, M_DENY = 2, M_OPEN = 3, M_COMMIT = 4, M_WAITC = 5;
  int       m_ph   [2];
  int       m_cnt  [2];
  bit       m_uni  [2];
  bit       m_deb  [2];
  bit [5:0] m_hist [2];
  int       m_hour;

  always @(posedge clk or negedge rst_n) begin : model
    bit sens [2];
    bit badge [2];
    bit nd;
    bit ex_busy;
    bit ok;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = M_IDLE; m_cnt[i] = 0; m_uni[i] = 0; m_deb[i] = 0; m_hist[i] = '0;
      end
      m_hour = HOUR_RESET;
    end else begin
      sens[0] = entry_sensor;     sens[1] = exit_sensor;
      badge[0] = entry_badge_uni; badge[1] = exit_badge_uni;
      ex_busy = (m_ph[1] == M_COMMIT);
      for (int i = 0; i < 2; i++) begin
        nd = m_deb[i];
        if (m_hist[i][4:1] == 4'b1111) nd = 1'b1;
        else if (m_hist[i][4:1] == 4'b0000) nd = 1'b0;
        case (m_ph[i])
          M_IDLE:   if (nd && !m_deb[i]) m_ph[i] = M_CHECK;
          M_CHECK: begin
            m_uni[i] = badge[i];
            ok = (i == 1) || (badge[i] ? uni_is_vacated_space : is_vacated_space);
            if (ok) begin m_ph[i] = M_OPEN; m_cnt[i] = 1; end
            else m_ph[i] = M_DENY;
          end
          M_DENY:   m_ph[i] = M_WAITC;
          M_OPEN: begin
            if (m_cnt[i] == TIMEOUT) m_ph[i] = M_WAITC;
            else if (!m_deb[i]) m_ph[i] = M_COMMIT;
            else m_cnt[i] = m_cnt[i] + 1;
          end
          M_COMMIT: if (i == 1 || !ex_busy) m_ph[i] = M_IDLE;
          M_WAITC:  if (!m_deb[i]) m_ph[i] = M_IDLE;
          default:  m_ph[i] = M_IDLE;
        endcase
        m_deb[i]  = nd;
        m_hist[i] = {m_hist[i][4:0], sens[i]};
      end
      if (hour_load) m_hour = (hour_in > 23) ? 23 : int'(hour_in);
      else if (hour_tick) m_hour = (m_hour + 1) % 24;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
    hour_tick = 1'b0; hour_load = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [8:0] pulses;
    tick(); tick();
    pulses = {entry_gate_open, exit_gate_open, entry_denied, entry_abort, exit_abort,
              car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
    n_checks++;
    if (pulses !== 9'd0) $display("FAIL reset_outputs: got %b expected 0", pulses); else n_pass++;
    n_checks++;
    if (current_hour !== 5'd8) $display("FAIL reset_hour: got %0d expected 8", current_hour); else n_pass++;
    rst_n = 1'b1;
    tick();
    hour_load = 1'b1; hour_in = 5'd15;
    tick();
    hour_load = 1'b0; is_vacated_space = 1'b1; entry_badge_uni = 1'b0; entry_sensor = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    n_checks++;
    if (entry_gate_open !== 1'b1) $display("FAIL reset_pre_open: got %b expected 1", entry_gate_open); else n_pass++;
    rst_n = 1'b0; entry_sensor = 1'b0;
    #1;
    n_checks++;
    if (entry_gate_open !== 1'b0) $display("FAIL reset_gate_drop: got %b expected 0", entry_gate_open); else n_pass++;
    n_checks++;
    if (current_hour !== 5'd8) $display("FAIL reset_mid_hour: got %0d expected 8", current_hour); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    pulses = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses |= {entry_gate_open, exit_gate_open, entry_denied, entry_abort, exit_abort,
                 car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
    end
    n_checks++;
    if (pulses !== 9'd0) $display("FAIL reset_quiet_after: got %b expected 0", pulses); else n_pass++;
  endtask

  task automatic test_uni_entry();
    int gate_k, ce_k, ce_n;
    bit uni_seen, gate_after;
    apply_reset();
    gate_k = 0; ce_k = 0; ce_n = 0; uni_seen = 0; gate_after = 0;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0; entry_badge_uni = 1'b1;
    entry_sensor = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (entry_gate_open && gate_k == 0) gate_k = k;
      if (car_entered) begin
        ce_n++;
        if (ce_k == 0) ce_k = k;
        uni_seen = is_uni_car_entered;
        gate_after = entry_gate_open;
      end
      if (k == 10) entry_sensor = 1'b0;
    end
    n_checks++;
    if (gate_k != 7) $display("FAIL uni_gate_open_cycle: got %0d expected 7", gate_k); else n_pass++;
    n_checks++;
    if (ce_k != 17) $display("FAIL uni_commit_cycle: got %0d expected 17", ce_k); else n_pass++;
    n_checks++;
    if (ce_n != 1) $display("FAIL uni_commit_count: got %0d expected 1", ce_n); else n_pass++;
    n_checks++;
    if (uni_seen !== 1'b1 || gate_after !== 1'b0)
      $display("FAIL uni_flag_gate: got uni=%b gate=%b expected uni=1 gate=0", uni_seen, gate_after);
    else n_pass++;
  endtask

  task automatic test_denied();
    int den_n, den_k, gate_n, ce_n, gate_k;
    apply_reset();
    den_n = 0; den_k = 0; gate_n = 0; ce_n = 0; gate_k = 0;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0; entry_badge_uni = 1'b0;
    entry_sensor = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (entry_denied) begin den_n++; if (den_k == 0) den_k = k; end
      if (entry_gate_open) gate_n++;
      if (car_entered) ce_n++;
      if (k == 10) entry_sensor = 1'b0;
    end
    n_checks++;
    if (den_n != 1 || den_k != 7) $display("FAIL deny_pulse: got n=%0d at %0d expected n=1 at 7", den_n, den_k); else n_pass++;
    n_checks++;
    if (gate_n != 0 || ce_n != 0) $display("FAIL deny_no_open: got gate=%0d commit=%0d expected 0 0", gate_n, ce_n); else n_pass++;
    is_vacated_space = 1'b1;
    entry_sensor = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (entry_gate_open && gate_k == 0) gate_k = k;
    end
    entry_sensor = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (gate_k != 7) $display("FAIL deny_retrigger: got %0d expected 7", gate_k); else n_pass++;
  endtask

  task automatic test_timeout();
    int gate_n, gate_k, ab_n, ab_k, ce_n;
    apply_reset();
    gate_n = 0; gate_k = 0; ab_n = 0; ab_k = 0; ce_n = 0;
    is_vacated_space = 1'b1; entry_badge_uni = 1'b0;
    entry_sensor = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (entry_gate_open) begin gate_n++; if (gate_k == 0) gate_k = k; end
      if (entry_abort) begin ab_n++; if (ab_k == 0) ab_k = k; end
      if (car_entered) ce_n++;
      if (k == 30) entry_sensor = 1'b0;
    end
    n_checks++;
    if (gate_n != TIMEOUT || gate_k != 7)
      $display("FAIL timeout_gate: got %0d cycles from %0d expected 16 from 7", gate_n, gate_k);
    else n_pass++;
    n_checks++;
    if (ab_n != 1 || ab_k != 22) $display("FAIL timeout_abort: got n=%0d at %0d expected n=1 at 22", ab_n, ab_k); else n_pass++;
    n_checks++;
    if (ce_n != 0) $display("FAIL timeout_no_commit: got %0d expected 0", ce_n); else n_pass++;
    entry_sensor = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (car_entered) ce_n++;
      if (k == 5) entry_sensor = 1'b0;
    end
    n_checks++;
    if (ce_n != 1) $display("FAIL timeout_rearrive: got %0d expected 1", ce_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ce_k, cx_k, ce_n, cx_n;
    bit both, ce_uni, cx_uni;
    apply_reset();
    ce_k = 0; cx_k = 0; ce_n = 0; cx_n = 0; both = 0; ce_uni = 0; cx_uni = 1;
    is_vacated_space = 1'b1; entry_badge_uni = 1'b1; exit_badge_uni = 1'b0;
    entry_sensor = 1'b1; exit_sensor = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (car_entered && car_exited) both = 1;
      if (car_entered) begin ce_n++; if (ce_k == 0) ce_k = k; ce_uni = is_uni_car_entered; end
      if (car_exited) begin cx_n++; if (cx_k == 0) cx_k = k; cx_uni = is_uni_car_exited; end
      if (k == 8) begin entry_sensor = 1'b0; exit_sensor = 1'b0; end
    end
    n_checks++;
    if (cx_k != 15 || ce_k != 16) $display("FAIL arb_order: got exit=%0d entry=%0d expected 15 16", cx_k, ce_k); else n_pass++;
    n_checks++;
    if (both || ce_n != 1 || cx_n != 1)
      $display("FAIL arb_single: got both=%b ce=%0d cx=%0d expected 0 1 1", both, ce_n, cx_n);
    else n_pass++;
    n_checks++;
    if (ce_uni !== 1'b1 || cx_uni !== 1'b0) $display("FAIL arb_uni: got %b%b expected 10", ce_uni, cx_uni); else n_pass++;
  endtask

  task automatic test_hour();
    hour_load = 1'b1; hour_in = 5'd23;
    tick();
    hour_load = 1'b0; hour_tick = 1'b1;
    tick();
    hour_tick = 1'b0;
    n_checks++;
    if (current_hour !== 5'd0) $display("FAIL hour_wrap: got %0d expected 0", current_hour); else n_pass++;
    hour_load = 1'b1; hour_tick = 1'b1; hour_in = 5'd13;
    tick();
    n_checks++;
    if (current_hour !== 5'd13) $display("FAIL hour_load_wins: got %0d expected 13", current_hour); else n_pass++;
    hour_tick = 1'b0; hour_in = 5'd30;
    tick();
    hour_load = 1'b0;
    n_checks++;
    if (current_hour !== 5'd23) $display("FAIL hour_clamp: got %0d expected 23", current_hour); else n_pass++;
    hour_tick = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    hour_tick = 1'b0;
    n_checks++;
    if (current_hour !== 5'd4) $display("FAIL hour_count: got %0d expected 4", current_hour); else n_pass++;
  endtask

  task automatic test_random();
    bit         lvl  [2];
    int         hold [2];
    logic [13:0] obs, exp;
    bit eg, xg, ce, cx;
    apply_reset();
    lvl[0] = 0; lvl[1] = 0; hold[0] = 3; hold[1] = 7;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = ~lvl[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 28);
        end
        hold[i]--;
      end
      entry_sensor         = lvl[0];
      exit_sensor          = lvl[1];
      entry_badge_uni      = $urandom_range(0, 1);
      exit_badge_uni       = $urandom_range(0, 1);
      uni_is_vacated_space = ($urandom_range(0, 9) < 7);
      is_vacated_space     = ($urandom_range(0, 9) < 7);
      hour_tick            = ($urandom_range(0, 7) == 0);
      hour_load            = ($urandom_range(0, 63) == 0);
      hour_in              = 5'($urandom_range(0, 31));
      rst_n                = !((c >= 1000 && c < 1002) || (c >= 2000 && c < 2002));
      tick();
      eg = (m_ph[0] == M_OPEN);
      xg = (m_ph[1] == M_OPEN);
      cx = (m_ph[1] == M_COMMIT);
      ce = (m_ph[0] == M_COMMIT) && !cx;
      exp = {eg, xg, m_ph[0] == M_DENY, eg && m_cnt[0] == TIMEOUT, xg && m_cnt[1] == TIMEOUT,
             ce, ce && m_uni[0], cx, cx && m_uni[1], 5'(m_hour)};
      obs = {entry_gate_open, exit_gate_open, entry_denied, entry_abort, exit_abort,
             car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, current_hour};
      n_checks++;
      if (obs !== exp) $display("FAIL random_cycle_%0d: got %b expected %b", c, obs, exp); else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_uni_entry();
    test_denied();
    test_timeout();
    test_back_to_back();
    test_hour();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
Upstream front-end for the parking manager. It converts raw entry/exit loop sensors and a university badge reader into the single-cycle car_entered/car_exited (+is_uni) commit pulses the manager consumes, and maintains current_hour. It gates entry on the manager's vacancy flags, drives the two barriers, and serialises commits so the manager never sees an entry and an exit in the same cycle.

Parameters:
DEBOUNCE, 4, consecutive synchronised cycles a sensor must hold a new level before it is accepted
TIMEOUT, 16, max cycles a barrier stays open waiting for the car to clear before aborting
HOUR_RESET, 8, current_hour value after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
entry_sensor  in  1  raw entry loop, async, 1 = car present
exit_sensor  in  1  raw exit loop, async, 1 = car present
entry_badge_uni  in  1  badge reader at entry, sampled in CHECK, 1 = university car
exit_badge_uni  in  1  badge reader at exit, sampled in CHECK
uni_is_vacated_space  in  1  from manager, university space available
is_vacated_space  in  1  from manager, general space available
hour_tick  in  1  one-cycle pulse, advance hour
hour_load  in  1  load hour_in (wins over hour_tick)
hour_in  in  5  hour value to load, 0..23
current_hour  out  5  to manager
car_entered  out  1  one-cycle commit pulse
is_uni_car_entered  out  1  valid with car_entered
car_exited  out  1  one-cycle commit pulse
is_uni_car_exited  out  1  valid with car_exited
entry_gate_open  out  1  entry barrier command
exit_gate_open  out  1  exit barrier command
entry_denied  out  1  one-cycle pulse, entry refused (no space)
entry_abort  out  1  one-cycle pulse, entry timed out
exit_abort  out  1  one-cycle pulse, exit timed out

Behaviour:
- Reset (async assert, sync deassert use): all pulses and gate outputs 0, both FSMs IDLE, debounce counters 0, current_hour = HOUR_RESET.
- Sensors: 2-FF synchroniser, then debounce; debounced level changes only after DEBOUNCE consecutive equal synchronised samples. Sensor rise to debounced rise = 2 + DEBOUNCE cycles.
- Hour: hour_load -> current_hour = hour_in (values >23 clamp to 23); else hour_tick -> +1, 23 wraps to 0.
- Entry FSM: IDLE -(debounced rise)-> CHECK (1 cycle; latch entry_badge_uni into uni_q). In CHECK: space = uni_q ? uni_is_vacated_space : is_vacated_space. space=1 -> OPEN; space=0 -> DENY (pulse entry_denied once) -> WAIT_CLEAR.
- OPEN: entry_gate_open=1, timer counts. Debounced fall before timer reaches TIMEOUT -> COMMIT; timer == TIMEOUT -> pulse entry_abort, gate closes, -> WAIT_CLEAR, no commit.
- COMMIT: request commit; when granted, car_entered=1, is_uni_car_entered=uni_q for exactly one cycle -> IDLE. Gate closes on leaving OPEN.
- WAIT_CLEAR: stay until debounced level 0 -> IDLE.
- Exit FSM identical minus space check (CHECK always -> OPEN); exit_abort on timeout; commit drives car_exited/is_uni_car_exited.
- Arbitration: at most one commit pulse per cycle. Both pending same cycle -> exit granted first, entry granted next cycle. Pending commit holds in COMMIT until granted.
- is_uni_* are 0 whenever their strobe is 0.
- Sensor still 1 on return to IDLE does not retrigger; a new debounced rise is required.
- Reset mid-operation: gates drop immediately, pending commits discarded.

Test Plan:
- Reset with rst_n=0 mid-OPEN -> entry_gate_open=0 same cycle, current_hour=8, no pulses after release.
- Entry uni car, uni_is_vacated_space=1: sensor high 10 cycles then low -> gate opens at cycle 7 (2+4+1), car_entered and is_uni_car_entered high exactly 1 cycle after debounced fall.
- Entry general car, is_vacated_space=0 -> entry_denied 1 pulse, gate never opens, no car_entered; sensor low then high again -> new CHECK.
- Car stays on loop 30 cycles with TIMEOUT=16 -> entry_abort pulse at 16th open cycle, gate closes, no commit until sensor clears and re-arrives.
- Entry and exit commit ready in same cycle -> car_exited at cycle N, car_entered at N+1, never both high.
- hour_tick at 23 -> 0; hour_load=1 with hour_tick=1, hour_in=13 -> 13; hour_in=30 -> 23.
